// File: rtl/uart_pkg.sv
// Shared UART types and constants for the TX block and the future RX block.
// No logic; no latency; no backpressure.
// Frame timing constants default to 115200 baud from a 100 MHz core clock.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick marks the last clock of each CLKS_PER_BIT period.
// Latency: tick is CLKS_PER_BIT cycles after restart; no backpressure, free-running.
// restart zeroes the count so a bit period starts exactly at the handshake edge.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART serialiser (8N1 by default, even parity with UART_TX_PARITY_EN), LSB first.
// Latency: tx falls one clock after the txValid/txReady handshake; frame then runs to completion.
// Backpressure: txReady is high only in IDLE and is decoded from the state register alone.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tx_data,
    input  logic        txValid,
    output logic        txReady,
    output logic        tx,
    output logic        busy,
    output logic        tx_done
);

    localparam int BIT_W = $clog2(DATA_BITS) + 1;
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    uart_tx_state_e state_q;
    uart_tx_state_e state_d;

    logic [DATA_BITS-1:0] shift_q;
    logic [BIT_W-1:0]     bit_q;
    logic                 tx_q;
    logic                 tx_d;
    logic                 tx_done_q;
    logic                 done_d;
    logic                 bit_tick;
    logic                 handshake;
    logic                 last_data;
    logic                 last_stop;

    // Upper bits of the bank word are never part of the frame.
    logic [31:0] unused_tx_data;
    assign unused_tx_data = tx_data;

    assign txReady   = (state_q == IDLE);
    assign busy      = ~txReady;
    assign handshake = txValid && txReady;
    assign last_data = (bit_q == DATA_LAST);
    assign last_stop = (bit_q == STOP_LAST);
    assign tx        = tx_q;
    assign tx_done   = tx_done_q;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .restart  (handshake),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (txValid) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick && last_data) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick && last_stop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // bit_q indexes data bits in DATA and is reused as the stop-bit count in STOP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            bit_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        shift_q <= tx_data[DATA_BITS-1:0];
                        bit_q   <= '0;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        bit_q <= '0;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                        bit_q   <= last_data ? '0 : bit_q + BIT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        bit_q <= bit_q + BIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UART_TX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else if (handshake) begin
            par_q <= ^tx_data[DATA_BITS-1:0];
        end
    end
`endif

    always_comb begin
        tx_d   = 1'b1;
        done_d = 1'b0;
        case (state_q)
            START: tx_d = 1'b0;
            DATA:  tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = par_q;
`endif
            STOP: begin
                tx_d   = 1'b1;
                done_d = bit_tick && last_stop;
            end
            default: tx_d = 1'b1;
        endcase
    end

    // Registered line and done so the pin is glitch-free; reset forces the line high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            tx_q      <= tx_d;
            tx_done_q <= done_d;
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART 8N1 serialiser that sits downstream of the AXI4-Lite register bank.
- Consumes the register bank's tx word (tx_data/txValid) through a valid/ready handshake and drives the serial TX pin, LSB first.
- Produces the txReady that clears the register bank's txValid.
- Transmit-side counterpart of the RX path feeding rx_data/rxValid.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range >= 2.
- DATA_BITS, 8, data bits per frame; taken from tx_data[DATA_BITS-1:0].
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset; asynchronous assert, active-low; the only reset.
- tx_data  input  32  word from the register bank; only [DATA_BITS-1:0] is used, the rest is ignored.
- txValid  input  1  tx_data holds a byte to send.
- txReady  output  1  high only in IDLE; a byte is accepted on any edge where txValid && txReady.
- tx  output  1  serial line; idles high.
- busy  output  1  high whenever state != IDLE.
- tx_done  output  1  one-cycle pulse in the cycle the last stop bit completes.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx=1, txReady=1, busy=0, tx_done=0; shift, bit and baud counters cleared.
- Reset mid-frame aborts the frame immediately: tx returns to 1 without waiting for a clock, and the byte is discarded.
- States (uart_tx_state_e): IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - tx=1, txReady=1.
  - On txValid=1 at edge N, latch tx_data[DATA_BITS-1:0] into the shift register and go to START.
  - tx falls at edge N+1 (1-cycle latency).
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment bit_idx.
  - After bit DATA_BITS-1, go to PARITY if compiled in, otherwise STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the last cycle, assert tx_done for 1 cycle and go to IDLE.
- Frame length: (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles, i.e. 10*CLKS_PER_BIT by default.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and is forced to 0 on handshake.
- Bit counter: width $clog2(DATA_BITS)+1, so there is no premature wrap at DATA_BITS.
- txReady is decoded from the state register only. There is no combinational path from txValid to txReady.
- txReady=0 from START through STOP. txValid held high during a frame is ignored, and tx_data changes during a frame do not affect the byte in flight.
- Back-to-back frames:
  - At least 1 IDLE cycle (tx=1) separates frames.
  - If txValid is already high on re-entering IDLE, the handshake occurs on that first IDLE edge.
- The register bank drops txValid one cycle after the handshake; uart_tx must not re-accept in that cycle, which is guaranteed because state has left IDLE.
- busy = !txReady.
- Simultaneous tx_done and a new txValid: tx_done is asserted in the STOP→IDLE transition cycle; the new byte is accepted at the following IDLE edge.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - After DATA, a PARITY state drives tx = ^byte (even parity, computed on the latched byte) for CLKS_PER_BIT cycles, then STOP.
  - Frame length becomes (2+DATA_BITS+STOP_BITS)*CLKS_PER_BIT.
- Undefined: the PARITY state and its logic are absent and the frame is 8N1.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] uart_tx_state_e {IDLE, START, DATA, PARITY, STOP}.
  - localparam DEFAULT_CLKS_PER_BIT = 868.
  - localparam UART_DATA_BITS = 8.
  - The enum and constants are shared with the future RX block.
- Sub-module uart_baud_gen(clk, rst, restart, bit_tick):
  - CLKS_PER_BIT-parameterised counter.
  - bit_tick pulses on the last cycle of each bit period.
  - restart zeroes the counter.
- uart_tx instantiates one uart_baud_gen and holds the FSM, shift register and bit counter.

Test Plan:
- Bench parameter CLKS_PER_BIT=4 throughout.
- Reset: rst=0 mid-DATA at an arbitrary phase -> tx=1, txReady=1, busy=0 immediately; after release, idle line stays 1 with no spurious frame.
- Single byte: tx_data=32'hDEAD_BE55, txValid pulse at edge N -> tx=0 for edges N+1..N+4, then bits 1,0,1,0,1,0,1,0 (0x55 LSB first) 4 cycles each, then stop=1 for 4 cycles; tx_done pulse; txReady back at N+41.
- Handshake hold-off: txValid held high with tx_data=0xA3, changing tx_data to 0x00 mid-frame -> frame carries 0xA3, txReady=0 for all 40 frame cycles, second frame 0x00 starts after exactly 1 IDLE cycle.
- Register-bank integration: write 0x41 through the wr_amba path -> txValid cleared one cycle after the handshake; exactly one frame 0x41 emitted.
- Stop bits: STOP_BITS=2, byte 0xFF -> line low only during the 4-cycle start bit; frame length 44 cycles.
- UART_TX_PARITY_EN defined: bytes 0x07 and 0x03 -> parity bit 1 for 0x07 (three ones) and 0 for 0x03 (two ones), each 4 cycles after bit 7; frame length 44 cycles.
